// File: rtl/efp_cplx_encoder_pkg.sv
// efp_pkg: shared constants and types for the EFP complex encoder.
//   EFP word: [23] sign, [22:17] exponent (bias E_BIAS), [16:0] right-aligned mantissa.
//   efp_s1_t is the per-lane state handed from the classify stage to the pack stage.
package efp_pkg;
    localparam int EFP_W           = 24;
    localparam int EXP_W           = 6;
    localparam int MAN_W           = 17;
    localparam int E_BIAS          = 31;
    localparam int FP32_TO_EFP_OFS = 127 - E_BIAS;   // 96

    typedef struct packed {
        logic             sgn;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } efp_t;

    typedef enum logic [1:0] {CLS_ZERO, CLS_NORM, CLS_SAT, CLS_UFLOW} efp_cls_e;

    typedef struct packed {
        efp_cls_e         cls;
        logic             sgn;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
        logic             grd;
        logic             stk;
    } efp_s1_t;

    function automatic logic [4:0] clamp_mbit(input logic [4:0] m);
        return (m > 5'd17) ? 5'd17 : m;
    endfunction
endpackage

// File: rtl/efp_cplx_encoder_if.sv
// efp_cplx_encoder_if: sample stream in (fp32 pair) and encoded stream out (EFP pair + flags).
//   master: producer/consumer side (testbench or upstream logic)
//   slave : encoder side
interface efp_cplx_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] fp_re;
    logic [31:0] fp_im;
    logic [4:0]  m_bit;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] efp_re;
    logic [23:0] efp_im;
    logic [4:0]  out_m_bit;
    logic        sat_flag;
    logic        uflow_flag;

    modport master (output in_valid, fp_re, fp_im, m_bit, out_ready,
                    input  in_ready, out_valid, efp_re, efp_im, out_m_bit, sat_flag, uflow_flag);
    modport slave  (input  in_valid, fp_re, fp_im, m_bit, out_ready,
                    output in_ready, out_valid, efp_re, efp_im, out_m_bit, sat_flag, uflow_flag);
endinterface

// File: rtl/efp_fp32_lane.sv
// efp_fp32_lane: combinational logic for one complex component.
//   fp_i/mb_i   -> s1_o          : unpack and classify (stage 1)
//   s1_i/s1_mb_i -> efp_o/sat_o/uf_o : round and pack (stage 2)
//   mb_i / s1_mb_i are already clamped to 0..17.
// Optional feature macro: EFP_RNE_EN (round-to-nearest-even; truncation otherwise).
module efp_fp32_lane
    import efp_pkg::*;
(
    input  logic [31:0] fp_i,
    input  logic [4:0]  mb_i,
    output efp_s1_t     s1_o,
    input  efp_s1_t     s1_i,
    input  logic [4:0]  s1_mb_i,
    output efp_t        efp_o,
    output logic        sat_o,
    output logic        uf_o
);
    localparam logic [7:0] OFS = 8'(FP32_TO_EFP_OFS);

    logic [7:0]  e;
    logic [22:0] f;
    logic [7:0]  ediff;
    logic [4:0]  shamt;
`ifdef EFP_RNE_EN
    logic [22:0] rem;
`endif

    always_comb begin
        s1_o  = '0;
        e     = fp_i[30:23];
        f     = fp_i[22:0];
        ediff = e - OFS;
        shamt = 5'd23 - mb_i;                 // 6..23, so guard bit always exists
        s1_o.sgn = fp_i[31];
        s1_o.exp = ediff[EXP_W-1:0];
        s1_o.man = MAN_W'(f >> shamt);        // top mb_i fraction bits, right-aligned
`ifdef EFP_RNE_EN
        rem      = f & ((23'd1 << shamt) - 23'd1);
        s1_o.grd = rem[shamt - 5'd1];
        s1_o.stk = |(rem & ((23'd1 << (shamt - 5'd1)) - 23'd1));
`endif
        if (e == 8'd0)              s1_o.cls = CLS_ZERO;
        else if (e == 8'd255)       s1_o.cls = CLS_SAT;
        else if (e < OFS + 8'd1)    s1_o.cls = CLS_UFLOW;
        else if (e > OFS + 8'd63)   s1_o.cls = CLS_SAT;
        else                        s1_o.cls = CLS_NORM;
    end

    logic [17:0] mask;
`ifdef EFP_RNE_EN
    logic        up;
    logic [17:0] sum;
`else
    logic        unused_rnd;
    assign unused_rnd = s1_i.grd ^ s1_i.stk;
`endif

    always_comb begin
        efp_o = '0;
        sat_o = 1'b0;
        uf_o  = 1'b0;
        mask  = (18'd1 << s1_mb_i) - 18'd1;
`ifdef EFP_RNE_EN
        // man[0] is 0 when m_bit==0, so it doubles as the LSB for the tie case
        up  = s1_i.grd & (s1_i.stk | s1_i.man[0]);
        sum = {1'b0, s1_i.man} + 18'(up);
`endif
        case (s1_i.cls)
            CLS_SAT: begin
                efp_o = '{sgn: s1_i.sgn, exp: '1, man: mask[MAN_W-1:0]};
                sat_o = 1'b1;
            end
            CLS_NORM: begin
`ifdef EFP_RNE_EN
                if (sum[s1_mb_i]) begin
                    // rounding overflowed the m_bit field
                    if (&s1_i.exp) begin
                        efp_o = '{sgn: s1_i.sgn, exp: '1, man: mask[MAN_W-1:0]};
                        sat_o = 1'b1;
                    end else begin
                        efp_o = '{sgn: s1_i.sgn, exp: s1_i.exp + 6'd1, man: '0};
                    end
                end else begin
                    efp_o = '{sgn: s1_i.sgn, exp: s1_i.exp, man: sum[MAN_W-1:0]};
                end
`else
                efp_o = '{sgn: s1_i.sgn, exp: s1_i.exp, man: s1_i.man};
`endif
            end
            CLS_UFLOW: uf_o = 1'b1;
            default: ;                        // zero: sign dropped
        endcase
    end
endmodule

// File: rtl/efp_cplx_encoder.sv
// efp_cplx_encoder: fp32 complex sample stream -> 24-bit EFP pair, 2-stage valid/ready pipe.
//   clk, rst_n  : clock, async active-low reset
//   bus         : efp_cplx_encoder_if.slave (input stream, output stream, flags)
//   cnt_clr     : synchronous clear of both event counters (wins over increment)
//   sat_cnt     : count of saturated lanes on output transfers
//   uflow_cnt   : count of underflowed lanes on output transfers
// Optional feature macro: EFP_RNE_EN (round-to-nearest-even in the lanes).
module efp_cplx_encoder
    import efp_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    efp_cplx_encoder_if.slave bus,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  sat_cnt,
    output logic [CNT_W-1:0]  uflow_cnt
);
    logic       s1_v_q, out_v_q;
    efp_s1_t    s1_re_d, s1_im_d, s1_re_q, s1_im_q;
    logic [4:0] mb_d, s1_mb_q, out_mb_q;
    efp_t       enc_re, enc_im, efp_re_q, efp_im_q;
    logic       sat_re, sat_im, uf_re, uf_im;
    logic [1:0] sat_l_q, uf_l_q;
    logic [CNT_W-1:0] sat_cnt_q, sat_cnt_d, uf_cnt_q, uf_cnt_d;
    logic       adv2, out_fire;

    assign mb_d     = clamp_mbit(bus.m_bit);
    assign adv2     = !out_v_q || bus.out_ready;
    assign out_fire = out_v_q && bus.out_ready;
    // whole-pipe stall: only refuse input when both stages hold data and output is blocked
    assign bus.in_ready = !s1_v_q || adv2;

    efp_fp32_lane u_re (.fp_i(bus.fp_re), .mb_i(mb_d), .s1_o(s1_re_d),
                        .s1_i(s1_re_q), .s1_mb_i(s1_mb_q), .efp_o(enc_re), .sat_o(sat_re), .uf_o(uf_re));
    efp_fp32_lane u_im (.fp_i(bus.fp_im), .mb_i(mb_d), .s1_o(s1_im_d),
                        .s1_i(s1_im_q), .s1_mb_i(s1_mb_q), .efp_o(enc_im), .sat_o(sat_im), .uf_o(uf_im));

    always_comb begin
        sat_cnt_d = sat_cnt_q;
        uf_cnt_d  = uf_cnt_q;
        if (cnt_clr) begin
            sat_cnt_d = '0;
            uf_cnt_d  = '0;
        end else if (out_fire) begin
            sat_cnt_d = sat_cnt_q + CNT_W'(sat_l_q[0]) + CNT_W'(sat_l_q[1]);
            uf_cnt_d  = uf_cnt_q  + CNT_W'(uf_l_q[0])  + CNT_W'(uf_l_q[1]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q    <= 1'b0;
            s1_re_q   <= '0;
            s1_im_q   <= '0;
            s1_mb_q   <= '0;
            out_v_q   <= 1'b0;
            efp_re_q  <= '0;
            efp_im_q  <= '0;
            out_mb_q  <= '0;
            sat_l_q   <= '0;
            uf_l_q    <= '0;
            sat_cnt_q <= '0;
            uf_cnt_q  <= '0;
        end else begin
            if (bus.in_ready) begin
                s1_v_q <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_re_q <= s1_re_d;
                    s1_im_q <= s1_im_d;
                    s1_mb_q <= mb_d;
                end
            end
            if (adv2) begin
                out_v_q <= s1_v_q;
                if (s1_v_q) begin
                    efp_re_q <= enc_re;
                    efp_im_q <= enc_im;
                    out_mb_q <= s1_mb_q;
                    sat_l_q  <= {sat_im, sat_re};
                    uf_l_q   <= {uf_im, uf_re};
                end
            end
            sat_cnt_q <= sat_cnt_d;
            uf_cnt_q  <= uf_cnt_d;
        end
    end

    assign bus.out_valid  = out_v_q;
    assign bus.efp_re     = efp_re_q;
    assign bus.efp_im     = efp_im_q;
    assign bus.out_m_bit  = out_mb_q;
    assign bus.sat_flag   = |sat_l_q;
    assign bus.uflow_flag = |uf_l_q;
    assign sat_cnt        = sat_cnt_q;
    assign uflow_cnt      = uf_cnt_q;
endmodule

// File: tb/tb_efp_cplx_encoder.sv
// Testbench for efp_cplx_encoder: vector table + scoreboard, plus stall, reset and
// counter-clear sequences. Expected rounding results follow EFP_RNE_EN.
module tb_efp_cplx_encoder;
    localparam int CNT_W = 16;
`ifdef EFP_RNE_EN
    localparam bit RNE = 1'b1;
`else
    localparam bit RNE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cnt_clr = 1'b0;
    logic [CNT_W-1:0] sat_cnt, uflow_cnt;

    always #5 clk = ~clk;

    efp_cplx_encoder_if bus();
    efp_cplx_encoder #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .cnt_clr(cnt_clr), .sat_cnt(sat_cnt), .uflow_cnt(uflow_cnt));

    typedef struct {
        logic [23:0] re;
        logic [23:0] im;
        logic [4:0]  mb;
        int          nsat;
        int          nuf;
    } exp_t;
    typedef struct {
        logic [31:0] fre;
        logic [31:0] fim;
        logic [4:0]  mb;
        exp_t        e;
    } vec_t;

    localparam int NV = 12;
    vec_t v[NV];
    exp_t sb[$];
    int nchk = 0, npass = 0;
    int m_sat = 0, m_uf = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        nchk++;
        if (act === want) npass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, want);
    endtask

    // scoreboard consumer: one record per output transfer
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n && bus.out_valid && bus.out_ready) begin
            chk("sb_nonempty", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("efp_re", 32'(bus.efp_re), 32'(e.re));
                chk("efp_im", 32'(bus.efp_im), 32'(e.im));
                chk("out_m_bit", 32'(bus.out_m_bit), 32'(e.mb));
                chk("sat_flag", 32'(bus.sat_flag), 32'(e.nsat != 0));
                chk("uflow_flag", 32'(bus.uflow_flag), 32'(e.nuf != 0));
                m_sat += e.nsat;
                m_uf  += e.nuf;
            end
        end
    end

    task automatic drive(input vec_t x);
        bus.in_valid = 1'b1;
        bus.fp_re    = x.fre;
        bus.fp_im    = x.fim;
        bus.m_bit    = x.mb;
    endtask

    // hold the sample until accepted; returns #1 after the accepting edge
    task automatic send(input vec_t x);
        bit ok;
        int n;
        n = 0;
        drive(x);
        do begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk); #1;
            n++;
        end while (!ok && n < 50);
        if (ok) sb.push_back(x.e);
        else chk("in_ready_timeout", 0, 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain", 32'(sb.size()), 0);
    endtask

    task automatic latency_check(input vec_t x, input string nm);
        send(x);
        bus.in_valid = 1'b0;
        chk({nm, "_lat1"}, 32'(bus.out_valid), 0);
        @(posedge clk); #1;
        chk({nm, "_lat2"}, 32'(bus.out_valid), 1);
        drain();
    endtask

    initial begin
        int acc;
        bit ok;
        v[0]  = '{32'h3F800000, 32'hC0000000, 5'd8,  '{24'h3E0000, 24'hC00000, 5'd8,  0, 0}};
        v[1]  = '{32'h3FC00000, 32'h3F800000, 5'd4,  '{24'h3E0008, 24'h3E0000, 5'd4,  0, 0}};
        v[2]  = '{32'h3FC00000, 32'h00000000, 5'd0,  '{24'h3E0000, 24'h000000, 5'd0,  0, 0}};
        v[3]  = '{32'h3FC00000, 32'h00000000, 5'd20, '{24'h3F0000, 24'h000000, 5'd17, 0, 0}};
        v[4]  = '{32'h3F8C0000, 32'h3F840000, 5'd4,
                  '{RNE ? 24'h3E0002 : 24'h3E0001, 24'h3E0000, 5'd4, 0, 0}};
        v[5]  = '{32'h60AD78EC, 32'h1E3CE508, 5'd8,  '{24'h7E00FF, 24'h000000, 5'd8,  1, 1}};
        v[6]  = '{32'h7F800000, 32'hFFC00000, 5'd3,  '{24'h7E0007, 24'hFE0007, 5'd3,  2, 0}};
        v[7]  = '{32'h80000000, 32'h00000001, 5'd8,  '{24'h000000, 24'h000000, 5'd8,  0, 0}};
        v[8]  = '{32'h30800000, 32'h30000000, 5'd8,  '{24'h020000, 24'h000000, 5'd8,  0, 1}};
        v[9]  = '{32'h4F800000, 32'hD0000000, 5'd8,  '{24'h7E0000, 24'hFE00FF, 5'd8,  1, 0}};
        v[10] = '{32'h3FFFFFFF, 32'h4FFFFFFF, 5'd8,
                  '{RNE ? 24'h400000 : 24'h3E00FF, 24'h7E00FF, 5'd8, RNE ? 1 : 0, 0}};
        v[11] = '{32'h3FE00000, 32'h00000000, 5'd0,
                  '{RNE ? 24'h400000 : 24'h3E0000, 24'h000000, 5'd0, 0, 0}};

        bus.in_valid = 1'b0; bus.fp_re = '0; bus.fp_im = '0; bus.m_bit = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_in_ready", 32'(bus.in_ready), 1);
        chk("rst_efp_re", 32'(bus.efp_re), 0);
        chk("rst_flags", 32'({bus.sat_flag, bus.uflow_flag}), 0);
        chk("rst_cnts", 32'({sat_cnt, uflow_cnt}), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        latency_check(v[0], "first");

        // back-to-back table, one sample per cycle
        for (int i = 0; i < NV; i++) send(v[i]);
        bus.in_valid = 1'b0;
        drain();
        chk("sat_cnt", 32'(sat_cnt), 32'(m_sat));
        chk("uflow_cnt", 32'(uflow_cnt), 32'(m_uf));

        // async reset with two samples in flight
        send(v[5]);
        send(v[6]);
        bus.in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(bus.out_valid), 0);
        chk("arst_cnts", 32'({sat_cnt, uflow_cnt}), 0);
        sb.delete();
        m_sat = 0; m_uf = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        latency_check(v[1], "post_rst");

        // output stall with continuous input
        bus.out_ready = 1'b0;
        acc = 0;
        drive(v[1]);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            ok = bus.in_ready;
            if (c >= 2) begin
                chk("stall_in_ready", 32'(ok), 0);
                chk("stall_out_valid", 32'(bus.out_valid), 1);
                chk("stall_hold_re", 32'(bus.efp_re), 32'(v[1].e.re));
                chk("stall_hold_im", 32'(bus.efp_im), 32'(v[1].e.im));
            end
            @(posedge clk); #1;
            if (ok) begin
                sb.push_back(v[1 + acc].e);
                acc++;
                drive(v[1 + acc]);
            end
        end
        chk("stall_accepts", 32'(acc), 2);
        bus.out_ready = 1'b1;
        send(v[3]);
        bus.in_valid = 1'b0;
        drain();

        // counter increment, then clear colliding with an output transfer
        send(v[6]);
        bus.in_valid = 1'b0;
        drain();
        chk("sat_cnt_inc", 32'(sat_cnt), 32'(m_sat));
        bus.out_ready = 1'b0;
        send(v[6]);
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("clr_pre_valid", 32'(bus.out_valid), 1);
        cnt_clr = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        m_sat = 0; m_uf = 0;
        chk("clr_sat_cnt", 32'(sat_cnt), 0);
        chk("clr_uflow_cnt", 32'(uflow_cnt), 0);
        chk("clr_consumed", 32'(bus.out_valid), 0);
        chk("clr_sb_empty", 32'(sb.size()), 0);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
